// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Feeder for a multiplexed 4-digit 7-segment display. Holds a
//            16-bit value as four nibbles, optionally converted to decimal by
//            serial shift-and-add-3. Scans the digits at a prescaled rate.
// Options  : SEG_SCAN_LEADING_ZERO_BLANK_EN - blank leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [15:0] value,
  input  logic       dec_mode,
  output logic       busy,
  output logic [3:0] digit_bcd,
  output logic [3:0] digit_sel,
  output logic       blank
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_TERM     = CNT_W'(REFRESH_DIV - 1);
  localparam logic [15:0]      c_OVERFLOW = 16'hEEEE;

  state_t      state_q, state_d;
  logic [15:0] disp_q,  disp_d;
  logic [15:0] bin_q,   bin_d;
  logic [19:0] bcd_q,   bcd_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0] pre_q;
  logic [1:0]  idx_q;
  logic [19:0] w_adj;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign w_adj = add3(bcd_q);

  // Converter and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      disp_q  <= 16'h0000;
      bin_q   <= 16'h0000;
      bcd_q   <= 20'h00000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Converter next-state: load capture, 16 shift steps, then one commit cycle.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (dec_mode) begin
            bin_d   = value;
            bcd_d   = 20'h00000;
            cnt_d   = 4'd0;
            state_d = S_SHIFT;
          end else begin
            disp_d  = value;
          end
        end
      end
      S_SHIFT: begin
        bcd_d = {w_adj[18:0], bin_q[15]};
        bin_d = {bin_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Whole display updates on one edge so no digit ever shows a mix.
        if (bcd_q[19:16] != 4'd0) begin
          disp_d = c_OVERFLOW;
        end else begin
          disp_d = bcd_q[15:0];
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Free-running refresh prescaler; digit index advances on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= 2'd0;
    end else if (pre_q == c_TERM) begin
      pre_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign digit_sel = 4'b0001 << idx_q;
  assign digit_bcd = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic w_blank;

  // Dark when this digit and everything above it are zero; digit 0 always lit.
  always_comb begin
    w_blank = 1'b0;
    case (idx_q)
      2'd1:    w_blank = (disp_q[15:4]  == 12'h000);
      2'd2:    w_blank = (disp_q[15:8]  == 8'h00);
      2'd3:    w_blank = (disp_q[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
  end

  assign blank = w_blank;
`else
  assign blank = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Scoreboard bench for seg_scan_ctrl with a decimal/hex reference
//            model and randomized loads and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        dec_mode = 1'b0;
  logic        busy;
  logic [3:0]  digit_bcd;
  logic [3:0]  digit_sel;
  logic        blank;

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dec_mode(dec_mode),
    .busy(busy), .digit_bcd(digit_bcd), .digit_sel(digit_sel), .blank(blank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected events: kind 0 = reset, 1 = busy rises, 2 = display set / busy low
  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } ev_t;
  ev_t sb[$];

  int tests = 0;
  int fails = 0;
  int s_busy_until = 0;

  // Reference: what the display should hold after a load.
  function automatic logic [15:0] ref_disp(input int v, input bit dec);
    if (!dec) return 16'(v);
    if (v > 9999) return 16'hEEEE;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: applies due scoreboard events, then compares every sampled cycle.
  bit          m_active = 0;
  int          m_rst_cyc = 0;
  logic [15:0] m_disp = 16'h0;
  bit          m_busy = 0;

  always @(negedge clk) begin
    int slot;
    int e_blank;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ev_t e;
      e = sb.pop_front();
      case (e.kind)
        0: begin m_active = 1; m_rst_cyc = e.cyc; m_disp = 16'h0; m_busy = 0; end
        1: m_busy = 1;
        default: begin m_disp = e.val; m_busy = 0; end
      endcase
    end
    if (m_active) begin
      slot = ((cyc - m_rst_cyc) / DIV) % 4;
      e_blank = 0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0) e_blank = 1;
`endif
      chk("busy", int'(busy), int'(m_busy));
      chk("digit_sel", int'(digit_sel), 1 << slot);
      chk("digit_bcd", int'(digit_bcd), int'((m_disp >> (4 * slot)) & 16'hF));
      chk("blank", int'(blank), e_blank);
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic do_reset();
    while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
    sb.push_back('{cyc + 1, 0, 16'h0});
    s_busy_until = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_load(input int v, input bit dec);
    load = 1'b1;
    value = 16'(v);
    dec_mode = dec;
    if (cyc >= s_busy_until) begin
      if (dec) begin
        sb.push_back('{cyc + 1, 1, 16'h0});
        sb.push_back('{cyc + 18, 2, ref_disp(v, 1'b1)});
        s_busy_until = cyc + 18;
      end else begin
        sb.push_back('{cyc + 1, 2, ref_disp(v, 1'b0)});
      end
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(16);
    do_load(16'hA3F0, 1'b0);
    idle(17);
    do_load(1234, 1'b1);
    idle(24);
    do_load(12345, 1'b1);
    idle(22);
    do_load(9999, 1'b1);
    idle(20);
    do_load(10000, 1'b1);
    idle(20);
    // Load ignored while busy, then reset aborts the conversion.
    do_load(5678, 1'b1);
    idle(3);
    do_load(9, 1'b1);
    idle(4);
    do_reset();
    idle(24);
    do_load(16'h0040, 1'b0);
    idle(17);
    do_load(16'h0000, 1'b0);
    idle(17);
    do_load(40, 1'b1);
    idle(21);
    for (int i = 0; i < 40; i++) begin
      int v;
      case ($urandom_range(0, 3))
        0: v = $urandom_range(9990, 10010);
        1: v = $urandom_range(0, 300);
        default: v = int'($urandom & 32'hFFFF);
      endcase
      do_load(v, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 24));
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    idle(24);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
